// File: rtl/pmu_i2c_master.sv
// pmu_i2c_master: byte-level single-master I2C engine for the PMU SCL/SDA pair.
// Serialises bytes handed over one at a time by the bus-interface controller,
// returns read bytes, and flags slave NACKs / clock-stretch timeouts in a sticky
// failure bit.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   scl, sda       open-drain bus lines (driven 0 or 'z only)
//   data           byte to send, held stable until data_latch
//   start          begin a transaction (IDLE only)
//   done           no more bytes (checked at each byte boundary and in DRAIN)
//   rw             1 = next byte is a write, 0 = next byte is a read
//   clear_failed   clears failed
//   data_latch     1-cycle pulse: current byte request taken
//   ready          high in IDLE
//   failed         sticky NACK / timeout flag
//   in_data        last read byte; in_data_valid pulses when it updates
module pmu_i2c_master #(
  parameter int CLK_DIV     = 50,
  parameter int STRETCH_MAX = 1024
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       done,
  input  logic       rw,
  input  logic       clear_failed,
  output logic       data_latch,
  output logic       ready,
  output logic       failed,
  output logic [7:0] in_data,
  output logic       in_data_valid
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(STRETCH_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, START_A, START_B, BOUNDARY,
    BIT_LOW, BIT_RISE, BIT_HIGH, BIT_FALL,
    ACK_LOW, ACK_RISE, ACK_HIGH, ACK_FALL,
    STOP_A, STOP_B, STOP_C, DRAIN
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [1:0]      scl_sy, sda_sy;
  logic            scl_s, sda_s;
  logic [7:0]      sr;
  logic            samp;
  logic [2:0]      bit_cnt;
  logic            is_read;
  logic            txn_fail;
  logic [SW-1:0]   stretch_cnt;
  logic            stretch_to;
  logic            fail_set;
  logic            scl_low_c, sda_low_c;
  logic            scl_oe, sda_oe;
  logic            bit_drv;

  assign scl = scl_oe ? 1'b0 : 1'bz;
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_s      = scl_sy[1];
  assign sda_s      = sda_sy[1];
  assign tick       = (div_cnt == DW'(CLK_DIV - 1));
  assign stretch_to = (stretch_cnt == SW'(STRETCH_MAX));
  assign bit_drv    = !is_read && !sr[7];

  // The divider restarts on every state change so each phase lasts exactly
  // CLK_DIV cycles; BOUNDARY alone is a single cycle.
  always_ff @(posedge clk) begin
    if (reset || state != state_nx) div_cnt <= '0;
    else if (tick)                  div_cnt <= '0;
    else                            div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], scl};
      sda_sy <= {sda_sy[0], sda};
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    fail_set = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = START_A;
      START_A:  if (tick) state_nx = START_B;
      START_B:  if (tick) state_nx = BIT_LOW;
      BOUNDARY: state_nx = done ? STOP_A : BIT_LOW;
      BIT_LOW:  if (tick) state_nx = BIT_RISE;
      BIT_RISE: if (tick) begin
        if (scl_s)           state_nx = BIT_HIGH;
        else if (stretch_to) begin state_nx = STOP_A; fail_set = 1'b1; end
      end
      BIT_HIGH: if (tick) state_nx = BIT_FALL;
      BIT_FALL: if (tick) state_nx = (bit_cnt == 3'd0) ? ACK_LOW : BIT_LOW;
      ACK_LOW:  if (tick) state_nx = ACK_RISE;
      ACK_RISE: if (tick) begin
        if (scl_s)           state_nx = ACK_HIGH;
        else if (stretch_to) begin state_nx = STOP_A; fail_set = 1'b1; end
      end
      ACK_HIGH: if (tick) begin
        state_nx = ACK_FALL;
        if (!is_read && sda_s) fail_set = 1'b1;
      end
      // A NACK still finishes the SCL pulse before the stop so SDA never
      // moves while SCL is high.
      ACK_FALL: if (tick) state_nx = txn_fail ? STOP_A : BOUNDARY;
      STOP_A:   if (tick) state_nx = STOP_B;
      STOP_B:   if (tick) begin
        if (scl_s)           state_nx = STOP_C;
        else if (stretch_to) begin state_nx = STOP_C; fail_set = 1'b1; end
      end
      STOP_C:   if (tick) state_nx = txn_fail ? DRAIN : IDLE;
      DRAIN:    if (done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    data_latch = 1'b0;
    ready      = 1'b0;
    scl_low_c  = 1'b0;
    sda_low_c  = 1'b0;
    case (state)
      IDLE:     begin ready = 1'b1; data_latch = start; end
      START_A:  sda_low_c = 1'b1;
      START_B:  begin scl_low_c = 1'b1; sda_low_c = 1'b1; end
      BOUNDARY: begin scl_low_c = 1'b1; data_latch = !done; end
      BIT_LOW, BIT_FALL:  begin scl_low_c = 1'b1; sda_low_c = bit_drv; end
      BIT_RISE, BIT_HIGH: sda_low_c = bit_drv;
      ACK_LOW, ACK_FALL:  scl_low_c = 1'b1;
      STOP_A:   begin scl_low_c = 1'b1; sda_low_c = 1'b1; end
      STOP_B:   sda_low_c = 1'b1;
      DRAIN:    data_latch = !done;
      default:  ;
    endcase
  end

  // datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_oe        <= 1'b0;
      sda_oe        <= 1'b0;
      sr            <= '0;
      samp          <= 1'b0;
      bit_cnt       <= '0;
      is_read       <= 1'b0;
      txn_fail      <= 1'b0;
      stretch_cnt   <= '0;
      in_data       <= '0;
      in_data_valid <= 1'b0;
    end else begin
      scl_oe        <= scl_low_c;
      sda_oe        <= sda_low_c;
      in_data_valid <= 1'b0;
      if (state == IDLE && start) begin
        sr       <= data;
        is_read  <= 1'b0;
        txn_fail <= 1'b0;
      end
      if (state == START_B || state == BOUNDARY) bit_cnt <= 3'd7;
      if (state == BOUNDARY && !done) begin
        is_read <= !rw;
        if (rw) sr <= data;
      end
      if (state != state_nx)
        stretch_cnt <= '0;
      else if (tick && !scl_s && (state == BIT_RISE || state == ACK_RISE || state == STOP_B))
        stretch_cnt <= stretch_cnt + SW'(1);
      if (state == BIT_HIGH && tick) samp <= sda_s;
      // Shift only once SCL is low again so the driven bit is stable across
      // the whole high phase.
      if (state == BIT_FALL && tick) begin
        sr      <= {sr[6:0], samp};
        bit_cnt <= bit_cnt - 3'd1;
        if (bit_cnt == 3'd0 && is_read) begin
          in_data       <= {sr[6:0], samp};
          in_data_valid <= 1'b1;
        end
      end
      if (fail_set) txn_fail <= 1'b1;
    end
  end

  // set wins over clear
  always_ff @(posedge clk) begin
    if (reset)             failed <= 1'b0;
    else if (fail_set)     failed <= 1'b1;
    else if (clear_failed) failed <= 1'b0;
  end

endmodule

// File: tb/tb_pmu_i2c_master.sv
// tb_pmu_i2c_master: directed bench for pmu_i2c_master with a clocked I2C slave
// model (ACK/NACK, read data, clock stretch) and a second instance whose SCL is
// held low to force a stretch timeout.
module tb_pmu_i2c_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wire scl, sda;
  pullup (scl);
  pullup (sda);

  logic [7:0] data;
  logic       start = 1'b0, done, rw, clear_failed = 1'b0;
  logic       data_latch, ready, failed, in_data_valid;
  logic [7:0] in_data;

  pmu_i2c_master #(.CLK_DIV(4), .STRETCH_MAX(1024)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .data(data), .start(start),
    .done(done), .rw(rw), .clear_failed(clear_failed), .data_latch(data_latch),
    .ready(ready), .failed(failed), .in_data(in_data), .in_data_valid(in_data_valid));

  // second instance: timeout with a tiny stretch limit
  wire scl2, sda2;
  pullup (scl2);
  pullup (sda2);
  logic       start2 = 1'b0, done2 = 1'b0, hold2 = 1'b0, arm2 = 1'b0;
  logic       dl2, rdy2, f2, idv2;
  logic [7:0] id2;
  assign scl2 = hold2 ? 1'b0 : 1'bz;

  pmu_i2c_master #(.CLK_DIV(4), .STRETCH_MAX(8)) dut2 (
    .clk(clk), .reset(reset), .scl(scl2), .sda(sda2), .data(8'hFF), .start(start2),
    .done(done2), .rw(1'b1), .clear_failed(1'b0), .data_latch(dl2),
    .ready(rdy2), .failed(f2), .in_data(id2), .in_data_valid(idv2));

  // ---------------- client model ----------------
  logic [7:0] tx_b [4];
  logic       tx_rw [4];
  logic [2:0] n_bytes = 3'd0;
  logic [2:0] idx = 3'd0;
  logic       client_rst = 1'b0;
  int         n_latch = 0, n_valid = 0, cyc = 0, n_dl2 = 0;

  assign data = tx_b[idx[1:0]];
  assign rw   = tx_rw[idx[1:0]];
  assign done = (idx >= n_bytes);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dl2) n_dl2 <= n_dl2 + 1;
    if (client_rst) begin
      idx <= 3'd0; n_latch <= 0; n_valid <= 0; n_dl2 <= 0;
    end else begin
      if (data_latch) begin idx <= idx + 3'd1; n_latch <= n_latch + 1; end
      if (in_data_valid) n_valid <= n_valid + 1;
    end
  end

  // ---------------- slave model ----------------
  logic       s_scl_low = 1'b0, s_sda_low = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       armed = 1'b0, tx_mode = 1'b0, m_ack = 1'b0;
  logic       nack_addr = 1'b0, stretch_en = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] tx_byte = 8'hA5;
  logic [7:0] rx_log [4];
  logic [2:0] rx_n = 3'd0;
  int         bitc = 0, byte_no = 0, pulses = 0, stops = 0, rise_n = 0;
  int         first_per = 0, max_per = 0, last_rise = 0, hold_cnt = 0;

  assign scl = s_scl_low ? 1'b0 : 1'bz;
  assign sda = s_sda_low ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    p_scl <= scl;
    p_sda <= sda;
    if (client_rst) begin
      pulses <= 0; stops <= 0; rx_n <= 3'd0; first_per <= 0; max_per <= 0;
      rise_n <= 0; m_ack <= 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt <= hold_cnt - 1;
        if (hold_cnt == 1) s_scl_low <= 1'b0;
      end
      if (p_scl && scl && p_sda && !sda) begin
        bitc <= 0; byte_no <= 0; armed <= 1'b0; tx_mode <= 1'b0;
        s_sda_low <= 1'b0; rise_n <= 0;
      end else if (p_scl && scl && !p_sda && sda) begin
        stops <= stops + 1;
      end else if (!p_scl && scl) begin
        rise_n <= rise_n + 1;
        if (rise_n == 1) first_per <= cyc - last_rise;
        if (rise_n > 0 && cyc - last_rise > max_per) max_per <= cyc - last_rise;
        last_rise <= cyc;
        if (bitc < 8) sh <= {sh[6:0], sda};
        else          m_ack <= sda;
        bitc <= bitc + 1;
      end else if (p_scl && !scl) begin
        if (armed) pulses <= pulses + 1;
        armed <= 1'b1;
        if (bitc == 8) begin
          if (!tx_mode) begin
            rx_log[rx_n[1:0]] <= sh;
            rx_n <= rx_n + 3'd1;
            s_sda_low <= !(nack_addr && byte_no == 0);
          end else s_sda_low <= 1'b0;
          if (byte_no == 0) tx_mode <= sh[0];
        end else if (bitc == 9) begin
          bitc <= 0;
          byte_no <= byte_no + 1;
          s_sda_low <= (tx_mode && byte_no == 0) ? !tx_byte[7] : 1'b0;
        end else if (tx_mode && byte_no >= 1 && bitc >= 1) begin
          s_sda_low <= !tx_byte[7 - bitc];
        end
        if (stretch_en && byte_no == 1 && bitc == 3) begin
          s_scl_low <= 1'b1;
          hold_cnt  <= 200;
        end
      end
    end
  end

  // second-instance monitor: hold SCL low after bit 3 starts
  logic p_scl2 = 1'b1, stop2_seen = 1'b0;
  int   falls2 = 0;
  always @(negedge clk) begin
    p_scl2 <= scl2;
    if (!arm2) begin
      falls2 <= 0; hold2 <= 1'b0; stop2_seen <= 1'b0;
    end else begin
      if (p_scl2 && !scl2) begin
        falls2 <= falls2 + 1;
        if (falls2 == 3) hold2 <= 1'b1;
      end
      if (f2 && !sda2) stop2_seen <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic [2:0] n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic r1, input logic r2);
    n_bytes = n;
    tx_b[0] = b0; tx_b[1] = b1; tx_b[2] = b2; tx_b[3] = 8'h00;
    tx_rw[0] = 1'b1; tx_rw[1] = r1; tx_rw[2] = r2; tx_rw[3] = 1'b1;
  endtask

  task automatic begin_txn();
    client_rst = 1'b1; step();
    client_rst = 1'b0; start = 1'b1; step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready && k < 20000) begin step(); k++; end
    chk(tag, ready, 1'b1);
    step(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    load(3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    step(3);
    // reset state
    chk("rst_ready", ready, 1'b1);
    chk("rst_failed", failed, 1'b0);
    chk("rst_latch", data_latch, 1'b0);
    chk("rst_in_data", in_data, 8'h00);
    chk("rst_valid", in_data_valid, 1'b0);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    reset = 1'b0;
    step(2);

    // three-byte write, slave ACKs
    load(3'd3, 8'h68, 8'h10, 8'h9D, 1'b1, 1'b1);
    begin_txn();
    chk("w3_busy", ready, 1'b0);
    wait_ready("w3_ready");
    chk("w3_latch", n_latch, 3);
    chk("w3_pulses", pulses, 27);
    chk("w3_rx_n", rx_n, 3);
    chk("w3_b0", rx_log[0], 8'h68);
    chk("w3_b1", rx_log[1], 8'h10);
    chk("w3_b2", rx_log[2], 8'h9D);
    chk("w3_period", first_per, 16);
    chk("w3_stop", stops, 1);
    chk("w3_failed", failed, 1'b0);

    // address NACK
    nack_addr = 1'b1;
    begin_txn();
    wait_ready("nk_ready");
    chk("nk_failed", failed, 1'b1);
    chk("nk_latch", n_latch, 3);
    chk("nk_pulses", pulses, 9);
    chk("nk_stop", stops, 1);
    chk("nk_rx", rx_log[0], 8'h68);
    nack_addr = 1'b0;

    // reset in the middle of bit 5 (failed is still set going in)
    load(3'd2, 8'h68, 8'h10, 8'h00, 1'b1, 1'b1);
    begin_txn();
    begin
      int k = 0;
      while (pulses < 4 && k < 2000) begin step(); k++; end
    end
    chk("mr_reach", pulses, 4);
    step(6);
    reset = 1'b1;
    step();
    chk("mr_scl", scl, 1'b1);
    chk("mr_sda", sda, 1'b1);
    chk("mr_ready", ready, 1'b1);
    chk("mr_failed", failed, 1'b0);
    reset = 1'b0;
    step(2);
    begin_txn();
    wait_ready("mr2_ready");
    chk("mr2_latch", n_latch, 2);
    chk("mr2_rx_n", rx_n, 2);
    chk("mr2_b1", rx_log[1], 8'h10);
    chk("mr2_stop", stops, 1);
    chk("mr2_failed", failed, 1'b0);

    // single-byte NACK then clear_failed
    nack_addr = 1'b1;
    load(3'd1, 8'h68, 8'h00, 8'h00, 1'b1, 1'b1);
    begin_txn();
    wait_ready("cf_ready");
    chk("cf_set", failed, 1'b1);
    chk("cf_latch", n_latch, 1);
    nack_addr = 1'b0;
    clear_failed = 1'b1; step();
    clear_failed = 1'b0;
    chk("cf_clear", failed, 1'b0);

    // write then single-byte read returning 0xA5
    load(3'd2, 8'h68, 8'h32, 8'h00, 1'b1, 1'b1);
    begin_txn();
    wait_ready("rd_w_ready");
    chk("rd_w_b1", rx_log[1], 8'h32);
    load(3'd2, 8'h69, 8'h00, 8'h00, 1'b0, 1'b1);
    begin_txn();
    wait_ready("rd_ready");
    chk("rd_data", in_data, 8'hA5);
    chk("rd_valid_len", n_valid, 1);
    chk("rd_master_nack", m_ack, 1'b1);
    chk("rd_latch", n_latch, 2);
    chk("rd_addr", rx_log[0], 8'h69);
    chk("rd_rx_n", rx_n, 1);
    chk("rd_stop", stops, 1);
    chk("rd_failed", failed, 1'b0);

    // clock stretch of 200 clk inside byte 1
    stretch_en = 1'b1;
    load(3'd3, 8'h68, 8'h10, 8'h9D, 1'b1, 1'b1);
    begin_txn();
    wait_ready("st_ready");
    stretch_en = 1'b0;
    chk("st_long_bit", max_per >= 200, 1'b1);
    chk("st_pulses", pulses, 27);
    chk("st_b1", rx_log[1], 8'h10);
    chk("st_b2", rx_log[2], 8'h9D);
    chk("st_failed", failed, 1'b0);

    // stretch timeout on the second instance
    arm2 = 1'b1;
    client_rst = 1'b1; step();
    client_rst = 1'b0; start2 = 1'b1; step();
    start2 = 1'b0;
    begin
      int k = 0;
      while (!f2 && k < 2000) begin step(); k++; end
    end
    chk("to_failed", f2, 1'b1);
    step(200);
    chk("to_stop_try", stop2_seen, 1'b1);
    chk("to_drain", n_dl2 >= 100, 1'b1);
    chk("to_busy", rdy2, 1'b0);
    done2 = 1'b1;
    step(3);
    chk("to_ready", rdy2, 1'b1);
    arm2 = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
